// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv unit: FSM states, Booth select codes, iteration count.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_PM   = 3'd1,
        SEL_P2M  = 3'd2,
        SEL_NM   = 3'd3,
        SEL_N2M  = 3'd4
    } sel_e;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned ITER       = MULT_WIDTH / 2;

endpackage

// File: rtl/booth_mult_iter_if.sv
// Start/operand/result handshake between the multdiv issue logic and the Booth multiplier.
interface booth_mult_iter_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             ctrl_MULT;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output ctrl_MULT,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY
    );

    modport slave (
        input  ctrl_MULT,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY
    );

endinterface

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: 3-bit multiplier window to partial-product select and negate flag.
module booth_recode
    import multdiv_pkg::*;
(
    input  logic [2:0] win_i,
    output sel_e       sel_o,
    output logic       neg_o
);

    always_comb begin
        sel_o = SEL_ZERO;
        unique case (win_i)
            3'b001, 3'b010: sel_o = SEL_PM;
            3'b011:         sel_o = SEL_P2M;
            3'b100:         sel_o = SEL_N2M;
            3'b101, 3'b110: sel_o = SEL_NM;
            default:        sel_o = SEL_ZERO;
        endcase
        neg_o = (sel_o == SEL_NM) || (sel_o == SEL_N2M);
    end

endmodule

// File: rtl/booth_mult_iter.sv
// Iterative radix-4 Booth signed multiplier, WIDTH/2 iterations per product.
// Optional BOOTH_EARLY_EXIT_EN: finish early once all remaining Booth digits are zero.
module booth_mult_iter
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    booth_mult_iter_if.slave   bus
);

    localparam int unsigned NumIter = WIDTH / 2;
    localparam int unsigned PW      = 2 * WIDTH + 1;
    localparam int unsigned CntW    = $clog2(NumIter) + 1;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    sel_e             sel;
    logic             neg;
    logic [WIDTH+1:0] m_ext, mag, addend, sum;
    logic [PW-1:0]    p_next;
    logic             last_iter;

    booth_recode u_recode (
        .win_i (p_q[2:0]),
        .sel_o (sel),
        .neg_o (neg)
    );

    always_comb begin
        m_ext = {{2{m_q[WIDTH-1]}}, m_q};
        mag   = '0;
        unique case (sel)
            SEL_PM, SEL_NM:   mag = m_ext;
            SEL_P2M, SEL_N2M: mag = m_ext << 1;
            default:          mag = '0;
        endcase
        addend = neg ? -mag : mag;
        sum    = {{2{p_q[PW-1]}}, p_q[PW-1:WIDTH+1]} + addend;
        // Add into the upper half and arithmetic-shift the whole register right by 2.
        p_next = {sum, p_q[WIDTH:2]};
    end

    assign last_iter = (cnt_q == CntW'(NumIter - 1));

`ifdef BOOTH_EARLY_EXIT_EN
    logic          early;
    logic [PW-1:0] p_early;

    always_comb begin
        early   = (p_q[WIDTH:0] == '0) || (&p_q[WIDTH:0]);
        p_early = $signed(p_q) >>> (2 * (NumIter - 32'(cnt_q)));
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        p_d     = p_q;
        res_d   = res_q;
        exc_d   = exc_q;
        rdy_d   = 1'b0;
        unique case (state_q)
            RUN: begin
                p_d   = p_next;
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = DONE;
`ifdef BOOTH_EARLY_EXIT_EN
                if (early) begin
                    p_d     = p_early;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                res_d   = p_q[WIDTH:1];
                exc_d   = (p_q[PW-1:WIDTH] != {(WIDTH + 1){p_q[WIDTH]}});
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default: ;
        endcase
        // A start always wins: it aborts any operation in flight.
        if (bus.ctrl_MULT) begin
            m_d     = bus.data_operandA;
            p_d     = {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            p_q     <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            p_q     <= p_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_booth_mult_iter.sv
// Directed self-checking bench for booth_mult_iter (default fixed-latency build).
module tb_booth_mult_iter;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    booth_mult_iter_if #(.WIDTH(32)) bus ();

    booth_mult_iter #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive a start pulse sampled by the next rising edge (edge 0).
    task automatic kick(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = 32'hDEAD_BEEF;
        bus.data_operandB = 32'hCAFE_F00D;
    endtask

    // Edges after edge 0 until RDY is seen; 0 means it never came.
    task automatic wait_rdy(output int edges);
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_res, input logic exp_exc);
        int e;
        kick(a, b);
        wait_rdy(e);
        check({tag, " latency"}, e, 17);
        check({tag, " result"}, bus.data_result, exp_res);
        check({tag, " exception"}, {31'd0, bus.data_exception}, {31'd0, exp_exc});
        @(posedge clock);
        #1;
        check({tag, " rdy one cycle"}, {31'd0, bus.data_resultRDY}, 32'd0);
    endtask

    initial begin
        int e;
        int spurious;
        bus.ctrl_MULT     = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("reset result", bus.data_result, 32'd0);
        check("reset exception", {31'd0, bus.data_exception}, 32'd0);
        check("reset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_mult("3x5", 32'd3, 32'd5, 32'h0000_000F, 1'b0);
        run_mult("-7x6", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0);
        run_mult("maxx2", 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
        run_mult("minx1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
        run_mult("-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_mult("minx-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        // Asynchronous reset part-way through an operation.
        kick(32'd55, 32'd77);
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midreset result", bus.data_result, 32'd0);
        check("midreset exception", {31'd0, bus.data_exception}, 32'd0);
        check("midreset rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        wait_rdy(e);
        check("midreset no rdy", e, 32'd0);
        run_mult("2x3", 32'd2, 32'd3, 32'd6, 1'b0);

        // Restart while running: the aborted product never signals RDY.
        spurious = 0;
        kick(32'd1234, 32'd5678);
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            if (bus.data_resultRDY) spurious++;
        end
        kick(32'd10, 32'd10);
        if (bus.data_resultRDY) spurious++;
        check("abort holds old result", bus.data_result, 32'd6);
        wait_rdy(e);
        check("abort no early rdy", spurious, 32'd0);
        check("abort latency", e, 32'd17);
        check("abort result", bus.data_result, 32'd100);
        @(posedge clock);
        #1;
        check("abort single pulse", {31'd0, bus.data_resultRDY}, 32'd0);

        // Start during the DONE cycle: old result still pulses, new one follows.
        kick(32'd100, 32'hFFFF_FFFD);
        repeat (16) @(posedge clock);
        #1;
        check("done-start pre rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        kick(32'd9, 32'd9);
        check("done-start rdy", {31'd0, bus.data_resultRDY}, 32'd1);
        check("done-start old result", bus.data_result, 32'hFFFF_FED4);
        wait_rdy(e);
        check("done-start new latency", e, 32'd17);
        check("done-start new result", bus.data_result, 32'd81);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
